regfile_access_ctrl: RTL

Initiator-side controller for the 32-entry, two-read/one-write register file. It accepts operand-fetch requests from decode, drives the register file's read and write selects, and tracks outstanding destinations in a scoreboard so that read-after-write hazards stall. It captures both operands into a valid/ready output stage for execute, and commits writeback results onto the register file's write port.

---
 rtl/regfile_pkg.sv | 26 ++
 rtl/regfile_scoreboard.sv | 44 ++++
 rtl/regfile_access_ctrl.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared types and constants for the register file access controller.
package regfile_pkg;

  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 7;
  localparam int DATA_W   = 32;
  localparam int IDX_W    = $clog2(NUM_REGS);

  // Write select value that matches no register; driven while the write port is idle.
  localparam logic [ADDR_W-1:0] RF_IDLE_SEL = 7'h7F;
  localparam logic [ADDR_W-1:0] NUM_REGS_A  = ADDR_W'(NUM_REGS);

  // Operand-fetch request as produced by decode.
  typedef struct packed {
    logic [ADDR_W-1:0] src_a;
    logic [ADDR_W-1:0] src_b;
    logic [ADDR_W-1:0] dst;
    logic              dst_en;
  } rf_req_t;

  // True when a select addresses a real register.
  function automatic logic in_range(input logic [ADDR_W-1:0] idx);
    return idx < NUM_REGS_A;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-destination scoreboard: one bit per register, set when a producer
// issues, cleared on its writeback. A set and a clear of the same bit in one
// cycle leaves the bit set, because the new producer is still outstanding.
module regfile_scoreboard
  import regfile_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                set_en,
  input  logic [ADDR_W-1:0]   set_idx,
  input  logic                clr_en,
  input  logic [ADDR_W-1:0]   clr_idx,
  input  logic [ADDR_W-1:0]   look_a,
  input  logic [ADDR_W-1:0]   look_b,
  output logic                hit_a,
  output logic                hit_b,
  output logic [NUM_REGS-1:0] pending
);

  logic [NUM_REGS-1:0] pending_q, pending_d;
  logic [NUM_REGS-1:0] set_mask, clr_mask;

  // Next pending vector and hazard lookups; out-of-range selects never match.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    set_mask = '0;
    clr_mask = '0;
    if (set_en && in_range(set_idx)) set_mask[set_idx[IDX_W-1:0]] = 1'b1;
    if (clr_en && in_range(clr_idx)) clr_mask[clr_idx[IDX_W-1:0]] = 1'b1;
    pending_d = (pending_q & ~clr_mask) | set_mask;
    hit_a     = in_range(look_a) && pending_q[look_a[IDX_W-1:0]];
    hit_b     = in_range(look_b) && pending_q[look_b[IDX_W-1:0]];
  end

  // Pending state register.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!reset) pending_q <= '0;
    else        pending_q <= pending_d;
  end

  assign pending = pending_q;

endmodule

// File: rtl/regfile_access_ctrl.sv
// Register file access controller: one-entry fetch stage S, scoreboard-based
// RAW stalls, valid/ready operand output, and writeback onto the write port.
// Optional macro REGFILE_BYPASS_EN forwards wb_data to a same-cycle reader;
// without it a source matching the live writeback stalls one cycle.
module regfile_access_ctrl
  import regfile_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [ADDR_W-1:0]   req_src_a,
  input  logic [ADDR_W-1:0]   req_src_b,
  input  logic [ADDR_W-1:0]   req_dst,
  input  logic                req_dst_en,
  output logic                op_valid,
  input  logic                op_ready,
  output logic [DATA_W-1:0]   op_a,
  output logic [DATA_W-1:0]   op_b,
  output logic [ADDR_W-1:0]   op_dst,
  output logic                op_dst_en,
  input  logic                wb_valid,
  input  logic [ADDR_W-1:0]   wb_dst,
  input  logic [DATA_W-1:0]   wb_data,
  output logic [ADDR_W-1:0]   rf_read_a,
  output logic [ADDR_W-1:0]   rf_read_b,
  input  logic [DATA_W-1:0]   rf_out_a,
  input  logic [DATA_W-1:0]   rf_out_b,
  output logic [ADDR_W-1:0]   rf_write_select,
  output logic [DATA_W-1:0]   rf_write_in,
  output logic [NUM_REGS-1:0] pending
);

  logic              s_valid_q, s_valid_d;
  rf_req_t           s_req_q, s_req_d;
  logic              op_valid_q, op_valid_d;
  logic [DATA_W-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
  logic [ADDR_W-1:0] op_dst_q, op_dst_d;
  logic              op_dst_en_q, op_dst_en_d;

  logic              wb_act, wb_hit_a, wb_hit_b;
  logic              pend_a, pend_b, haz_a, haz_b;
  logic [DATA_W-1:0] opnd_a, opnd_b;
  logic              s_advance, req_fire;

  // Writeback strobes are dropped while reset is held.
  assign wb_act = wb_valid && reset;

  regfile_scoreboard u_sb (
    .clk     (clk),
    .reset   (reset),
    .set_en  (s_advance && s_req_q.dst_en),
    .set_idx (s_req_q.dst),
    .clr_en  (wb_act),
    .clr_idx (wb_dst),
    .look_a  (s_req_q.src_a),
    .look_b  (s_req_q.src_b),
    .hit_a   (pend_a),
    .hit_b   (pend_b),
    .pending (pending)
  );

  // Hazard detection and operand selection for the sources held in S.
  always_comb begin
    wb_hit_a = wb_act && in_range(s_req_q.src_a) && (wb_dst == s_req_q.src_a);
    wb_hit_b = wb_act && in_range(s_req_q.src_b) && (wb_dst == s_req_q.src_b);
`ifdef REGFILE_BYPASS_EN
    haz_a  = pend_a && !wb_hit_a;
    haz_b  = pend_b && !wb_hit_b;
    opnd_a = wb_hit_a ? wb_data : rf_out_a;
    opnd_b = wb_hit_b ? wb_data : rf_out_b;
`else
    haz_a  = pend_a || wb_hit_a;
    haz_b  = pend_b || wb_hit_b;
    opnd_a = rf_out_a;
    opnd_b = rf_out_b;
`endif
    if (!in_range(s_req_q.src_a)) opnd_a = '0;
    if (!in_range(s_req_q.src_b)) opnd_b = '0;
  end

  assign s_advance = s_valid_q && !haz_a && !haz_b && (!op_valid_q || op_ready);
  assign req_ready = !s_valid_q || s_advance;
  assign req_fire  = req_valid && req_ready;

  // Next state of stage S and of the operand output register.
  always_comb begin
    s_valid_d   = s_valid_q;
    s_req_d     = s_req_q;
    op_valid_d  = op_valid_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    op_dst_d    = op_dst_q;
    op_dst_en_d = op_dst_en_q;
    if (req_fire) begin
      s_valid_d = 1'b1;
      s_req_d   = '{src_a: req_src_a, src_b: req_src_b, dst: req_dst, dst_en: req_dst_en};
    end else if (s_advance) begin
      s_valid_d = 1'b0;
    end
    if (s_advance) begin
      op_valid_d  = 1'b1;
      op_a_d      = opnd_a;
      op_b_d      = opnd_b;
      op_dst_d    = s_req_q.dst;
      op_dst_en_d = s_req_q.dst_en;
    end else if (op_ready) begin
      op_valid_d = 1'b0;
    end
  end

  // Stage S and output register flops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s_valid_q   <= 1'b0;
      s_req_q     <= '0;
      op_valid_q  <= 1'b0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_dst_q    <= '0;
      op_dst_en_q <= 1'b0;
    end else begin
      s_valid_q   <= s_valid_d;
      s_req_q     <= s_req_d;
      op_valid_q  <= op_valid_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      op_dst_q    <= op_dst_d;
      op_dst_en_q <= op_dst_en_d;
    end
  end

  // Read selects follow S and keep their last value once S empties.
  assign rf_read_a       = s_req_q.src_a;
  assign rf_read_b       = s_req_q.src_b;
  assign rf_write_select = wb_act ? wb_dst : RF_IDLE_SEL;
  assign rf_write_in     = wb_act ? wb_data : '0;

  assign op_valid  = op_valid_q;
  assign op_a      = op_a_q;
  assign op_b      = op_b_q;
  assign op_dst    = op_dst_q;
  assign op_dst_en = op_dst_en_q;

endmodule
